// File: rtl/sha_msg_schedule.sv
// SHA-256 message-schedule expander: loads 16 big-endian words, then streams
// (W_t, K_t, t) for NUM_ROUNDS rounds over a valid/ready handshake.
module sha_msg_schedule #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_word_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_w_o,
  output logic [31:0] out_k_o,
  output logic [5:0]  out_round_o,
  output logic        out_last_o
);

  typedef enum logic {S_LOAD, S_EMIT} state_e;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  localparam logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [5:0]  round_q, round_d;
  logic [31:0] window_q [16];
  logic [31:0] window_d [16];
  logic [31:0] w_next;
  logic        load_fire, emit_fire;

  assign load_fire = (state_q == S_LOAD) && in_valid_i;
  assign emit_fire = (state_q == S_EMIT) && out_ready_i;
  assign w_next    = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    round_d  = round_q;
    window_d = window_q;

    if (load_fire || emit_fire) begin
      for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
      window_d[15] = load_fire ? in_word_i : w_next;
    end

    if (load_fire) begin
      count_d = count_q + 4'd1;
      if (count_q == 4'd15) begin
        state_d = S_EMIT;
        round_d = 6'd0;
      end
    end else if (emit_fire) begin
      if (round_q == LAST_ROUND) begin
        state_d = S_LOAD;
        count_d = 4'd0;
        round_d = 6'd0;
      end else begin
        round_d = round_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_LOAD;
      count_q <= 4'd0;
      round_q <= 6'd0;
      // NOTE: the window drives out_w_o directly, so it is reset to give a defined output.
      for (int i = 0; i < 16; i++) window_q[i] <= 32'd0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q  <= state_d;
      count_q  <= count_d;
      round_q  <= round_d;
      window_q <= window_d;
    end
  end

  assign in_ready_o  = (state_q == S_LOAD);
  assign out_valid_o = (state_q == S_EMIT);
  assign out_w_o     = window_q[0];
  assign out_k_o     = KROM[round_q];
  assign out_round_o = round_q;
  assign out_last_o  = (round_q == LAST_ROUND);

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Self-checking bench for sha_msg_schedule: directed "abc" cases plus random
// blocks checked against a FIPS 180-4 schedule model computed per block.
module tb_sha_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_w;
  logic [31:0] out_k;
  logic [5:0]  out_round;
  logic        out_last;

  int checks   = 0;
  int failures = 0;

  sha_msg_schedule #(.NUM_ROUNDS(64)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_word_i  (in_word),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_w_o    (out_w),
    .out_k_o    (out_k),
    .out_round_o(out_round),
    .out_last_o (out_last)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] blk     [16];
  logic [31:0] exp_w   [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-block schedule from the FIPS recurrence over an array of 64 words.
  task automatic build_schedule();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      logic [31:0] a, b;
      a = exp_w[t-2];
      b = exp_w[t-15];
      exp_w[t] = (rotr(a, 17) ^ rotr(a, 19) ^ (a >> 10)) + exp_w[t-7]
               + (rotr(b, 7) ^ rotr(b, 18) ^ (b >> 3)) + exp_w[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_round"}, 32'(out_round), 32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
  endtask

  // mode 0: in_valid always 1; 1: alternating 1/0; 2: random.
  task automatic load_block(input int mode);
    int i = 0;
    int c = 0;
    while (i < 16 && c < 1000) begin
      logic v;
      check("load_in_ready", 32'(in_ready), 32'd1);
      check("load_out_valid", 32'(out_valid), 32'd0);
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid  = v;
      in_word   = v ? blk[i] : $urandom;
      out_ready = 1'($urandom);
      @(negedge clk);
      if (v) i++;
      c++;
    end
    if (i < 16) check("load_timeout", 32'(i), 32'd16);
  endtask

  // Consume n rounds; stall_at >= 0 holds out_ready low for 5 cycles there.
  task automatic emit_block(input int n, input bit rand_ready, input int stall_at);
    int t = 0;
    int c = 0;
    int stalls = 0;
    while (t < n && c < 2000) begin
      logic r;
      check($sformatf("r%0d_out_valid", t), 32'(out_valid), 32'd1);
      check($sformatf("r%0d_in_ready", t), 32'(in_ready), 32'd0);
      check($sformatf("r%0d_round", t), 32'(out_round), 32'(t));
      check($sformatf("r%0d_W", t), out_w, exp_w[t]);
      check($sformatf("r%0d_K", t), out_k, K_REF[t]);
      check($sformatf("r%0d_last", t), 32'(out_last), 32'(t == 63));
      r = rand_ready ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      if (t == stall_at && stalls < 5) begin
        r = 1'b0;
        stalls++;
      end
      out_ready = r;
      in_valid  = 1'($urandom);
      in_word   = $urandom;
      @(negedge clk);
      if (r) t++;
      c++;
    end
    if (t < n) check("emit_timeout", 32'(t), 32'(n));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (n == 64) check_idle("after_last");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_word   = 32'hdeadbeef;
    out_ready = 1'b0;

    // T1: reset held two cycles with a word offered; it must not be taken.
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_out_W", out_w, 32'd0);
    check("reset_out_K", out_k, 32'h428a2f98);
    rst      = 1'b0;
    in_valid = 1'b0;

    // T2: "abc" block at full throughput.
    set_abc();
    build_schedule();
    check("abc_model_W16", exp_w[16], 32'h61626380);
    check("abc_model_W17", exp_w[17], 32'h000f0000);
    load_block(0);
    emit_block(64, 1'b0, -1);

    // T3: 5-cycle stall at round 20; values must stay at round 20 throughout.
    load_block(0);
    emit_block(64, 1'b0, 20);

    // T4: bubbles during load, in_valid toggling during emit.
    load_block(1);
    emit_block(64, 1'b0, -1);

    // T5: reset at round 30 discards the block.
    load_block(0);
    emit_block(30, 1'b0, -1);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    check("mid_reset_out_W", out_w, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    load_block(0);
    emit_block(64, 1'b0, -1);

    // T6: random blocks with random valid/ready.
    for (int b = 0; b < 100; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      build_schedule();
      load_block(2);
      emit_block(64, 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
